// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Serial output stage for the character port of brainfuckCore. Each character the core
//   emits is captured into a small FIFO. The transmitter then sends it as an 8N1 UART
//   frame, LSB first. The core cannot be stalled, so a character that arrives while the
//   FIFO is full is dropped, and the sticky overflow flag records the loss.
//
// Parameters
//   CLK_PER_BIT  clk cycles per UART bit (>= 2)
//   FIFO_LOG2    log2 of the FIFO depth (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   sendingChar  character-valid strobe; its rising edge is one write
//   sendedChar   character, sampled on the write edge
//   tx           UART serial line, registered, idles high
//   busy         a frame is in flight or the FIFO holds characters
//   fifo_full    FIFO holds 2^FIFO_LOG2 entries
//   overflow     sticky: a character was dropped since reset

module uart_tx_fifo #(
    parameter int unsigned CLK_PER_BIT = 16,
    parameter int unsigned FIFO_LOG2   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sendingChar,
    input  logic [7:0] sendedChar,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned Depth  = 1 << FIFO_LOG2;
    localparam int unsigned CountW = FIFO_LOG2 + 1;
    localparam int unsigned CntW   = $clog2(CLK_PER_BIT);

    localparam logic [CountW-1:0] DepthCount = CountW'(Depth);
    localparam logic [CntW-1:0]   CntLoad    = CntW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // Transmitter state
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    // Capture and FIFO state
    logic                 prev_q;
    logic [7:0]           mem_q [Depth];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]    count_q, count_d;
    logic                 overflow_q, overflow_d;

    logic       write;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] head;

    // Rising-edge detect: a level held high counts as a single character.
    assign write = sendingChar & ~prev_q;
    assign full  = (count_q == DepthCount);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A pop on the same edge frees the slot, so a write into a full FIFO is still taken.
    assign push = write & (~full | pop);

    //------------------------------------------------------------------------------------
    // Transmitter next-state
    //------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = CntLoad;
                    state_d = StStart;
                end
            end

            StStart: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntLoad;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            StData: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntLoad;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            StStop: begin
                if (cnt_q == '0) begin
                    if (!empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shift_d = head;
                        cnt_d   = CntLoad;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The line level is a function of the next state, registered so tx never glitches.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    //------------------------------------------------------------------------------------
    // FIFO bookkeeping
    //------------------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CountW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CountW'(1);
        end

        if (write && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    //------------------------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            prev_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            prev_q     <= sendingChar;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: clearing count is enough to discard the contents.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= sendedChar;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != StIdle) | ~empty;
    assign fifo_full = full;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with CLK_PER_BIT=4 and an 8-entry FIFO. A queue-based
//   model predicts tx/busy/fifo_full/overflow on every cycle. A line decoder recovers the
//   bytes that appear on tx, and literal expectations pin the model.

module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 4;
    localparam int unsigned LOG2  = 3;
    localparam int unsigned DEPTH = 1 << LOG2;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sendingChar = 1'b0;
    logic [7:0] sendedChar = 8'h00;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx_fifo #(
        .CLK_PER_BIT(CPB),
        .FIFO_LOG2  (LOG2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sendingChar(sendingChar),
        .sendedChar (sendedChar),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    //------------------------------------------------------------------------------------
    // Reference model. It is evaluated at the negedge. It first compares the DUT against
    // the state after the last edge, then advances using the inputs for the coming edge.
    //------------------------------------------------------------------------------------
    bit         m_valid = 0;
    bit         m_prev = 0;
    bit         m_active = 0;
    bit         m_ovf = 0;
    int         m_pos = 0;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_q[$];

    initial begin : model
        bit   w;
        bit   was_full;
        bit   do_pop;
        logic e_tx;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                if (!m_active)             e_tx = 1'b1;
                else if (m_pos < CPB)      e_tx = 1'b0;
                else if (m_pos < 9 * CPB)  e_tx = m_cur[(m_pos / CPB) - 1];
                else                       e_tx = 1'b1;
                check("tx", {31'd0, tx}, {31'd0, e_tx});
                check("busy", {31'd0, busy}, {31'd0, (m_active || m_q.size() != 0)});
                check("fifo_full", {31'd0, fifo_full}, {31'd0, (m_q.size() == DEPTH)});
                check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            end
            if (reset) begin
                m_valid  = 1;
                m_prev   = 0;
                m_active = 0;
                m_pos    = 0;
                m_ovf    = 0;
                m_q.delete();
            end else begin
                w        = sendingChar && !m_prev;
                m_prev   = sendingChar;
                was_full = (m_q.size() == DEPTH);
                do_pop   = (m_q.size() != 0) && (!m_active || m_pos == FRAME - 1);
                if (do_pop) begin
                    m_cur    = m_q.pop_front();
                    m_active = 1;
                    m_pos    = 0;
                end else if (m_active) begin
                    if (m_pos == FRAME - 1) m_active = 0;
                    else                    m_pos++;
                end
                if (w) begin
                    if (!was_full || do_pop) m_q.push_back(sendedChar);
                    else                     m_ovf = 1;
                end
            end
        end
    end

    //------------------------------------------------------------------------------------
    // Line decoder: recovers bytes from the DUT's tx, sampling mid-bit.
    //------------------------------------------------------------------------------------
    bit         rx_busy = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    initial begin : decoder
        forever begin
            @(negedge clk);
            if (reset) begin
                rx_busy = 0;
            end else if (!rx_busy) begin
                if (tx === 1'b0) begin
                    rx_busy = 1;
                    rx_cnt  = 0;
                end
            end else begin
                rx_cnt++;
                for (int i = 0; i < 8; i++) begin
                    if (rx_cnt == (i + 1) * CPB + CPB / 2) rx_byte[i] = tx;
                end
                if (rx_cnt == 9 * CPB + CPB / 2) begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    rx_q.push_back(rx_byte);
                    rx_busy = 0;
                end
            end
        end
    end

    //------------------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    //------------------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // The character is sampled on the edge inside this task.
    task automatic pulse(input logic [7:0] d);
        sendingChar = 1'b1;
        sendedChar  = d;
        tick();
        sendingChar = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy !== 1'b0 || rx_busy) && n < 5000) begin
            tick();
            n++;
        end
        check(name, {31'd0, (n < 5000)}, 32'd1);
    endtask

    task automatic check_rx(input string name);
        check({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit exp_bits[8] = '{1, 0, 0, 0, 0, 0, 1, 0};  // 0x41, LSB first
        int t0;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // Single character 0x41
        tick();
        rx_q.delete();
        pulse(8'h41);
        check("t1_busy_on_write", {31'd0, busy}, 32'd1);
        check("t1_tx_before", {31'd0, tx}, 32'd1);
        tick();
        check("t1_start", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            check($sformatf("t1_bit%0d", i), {31'd0, tx}, {31'd0, exp_bits[i]});
        end
        repeat (CPB) tick();
        check("t1_stop", {31'd0, tx}, 32'd1);
        repeat (CPB - 1) tick();
        check("t1_busy_last", {31'd0, busy}, 32'd1);
        tick();
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        wait_idle("t1_idle");
        exp_q = '{8'h41};
        check_rx("t1_rx");

        // Back-to-back frames
        do_reset();
        rx_q.delete();
        pulse(8'h55);
        t0 = cyc;
        tick();
        pulse(8'h00);
        tick();
        pulse(8'hFF);
        while (busy === 1'b1 && cyc - t0 < 1000) tick();
        check("t2_length", cyc - t0, 32'd121);
        wait_idle("t2_idle");
        exp_q = '{8'h55, 8'h00, 8'hFF};
        check_rx("t2_rx");

        // Overflow: ten pulses, the 10th is dropped
        do_reset();
        rx_q.delete();
        for (int k = 1; k <= 10; k++) begin
            pulse(8'(k));
            if (k == 8) check("t3_not_full_8", {31'd0, fifo_full}, 32'd0);
            if (k == 9) begin
                check("t3_full_9", {31'd0, fifo_full}, 32'd1);
                check("t3_ovf_9", {31'd0, overflow}, 32'd0);
            end
            if (k == 10) begin
                check("t3_full_10", {31'd0, fifo_full}, 32'd1);
                check("t3_ovf_10", {31'd0, overflow}, 32'd1);
            end
            if (k < 10) tick();
        end
        wait_idle("t3_idle");
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        exp_q.delete();
        for (int k = 1; k <= 9; k++) exp_q.push_back(8'(k));
        check_rx("t3_rx");

        // Reset mid-frame (overflow is still set from the previous test)
        rx_q.delete();
        pulse(8'h11);
        t0 = cyc;
        tick();
        pulse(8'h22);
        tick();
        pulse(8'h33);
        while (cyc - t0 < 18) tick();
        check("t5_bit3_low", {31'd0, tx}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_tx", {31'd0, tx}, 32'd1);
        check("t5_busy_clr", {31'd0, busy}, 32'd0);
        check("t5_ovf_clr", {31'd0, overflow}, 32'd0);
        check("t5_full_clr", {31'd0, fifo_full}, 32'd0);
        repeat (100) tick();
        check("t5_still_idle", {31'd0, busy}, 32'd0);
        check("t5_no_frames", rx_q.size(), 32'd0);

        // Level hold
        do_reset();
        rx_q.delete();
        sendingChar = 1'b1;
        sendedChar  = 8'h20;
        repeat (50) tick();
        sendingChar = 1'b0;
        wait_idle("t4_idle");
        check("t4_ovf", {31'd0, overflow}, 32'd0);
        exp_q = '{8'h20};
        check_rx("t4_rx");

        // Write into a full FIFO on the edge that pops
        do_reset();
        rx_q.delete();
        t0 = 0;
        for (int k = 1; k <= 9; k++) begin
            pulse(8'(k));
            if (k == 1) t0 = cyc;
            if (k < 9) tick();
        end
        check("t6_full", {31'd0, fifo_full}, 32'd1);
        while (cyc - t0 < 40) tick();
        sendingChar = 1'b1;
        sendedChar  = 8'd10;
        tick();
        sendingChar = 1'b0;
        check("t6_ovf", {31'd0, overflow}, 32'd0);
        check("t6_still_full", {31'd0, fifo_full}, 32'd1);
        wait_idle("t6_idle");
        check("t6_ovf_end", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        for (int k = 1; k <= 10; k++) exp_q.push_back(8'(k));
        check_rx("t6_rx");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
